// File: rtl/riscv_soft_host_loader_pkg.sv
// Shared encodings for the host loader: memory request opcodes/types,
// loader command opcodes and FSM state encoding.
package riscv_soft_host_loader_pkg;

  localparam int HOST_XPR_LEN = 32;

  localparam logic [1:0] MEM_LOAD   = 2'd0;
  localparam logic [1:0] MEM_STORE  = 2'd1;
  localparam logic [2:0] MEM_TYPE_W = 3'd2;

  localparam logic [7:0] OPC_WRITE = 8'h01;
  localparam logic [7:0] OPC_READ  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4,
    S_TX   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/riscv_soft_host_loader.sv
// Host-side loader: assembles byte-stream word read/write commands, issues
// them on the memory host port and streams back an ack or read data.
//
// state | meaning
// IDLE  | waiting for an opcode byte
// ADDR  | collecting 4 little-endian address bytes
// DATA  | collecting 4 little-endian write-data bytes
// REQ   | host_req_valid held until the memory accepts
// WAIT  | waiting for host_resp_valid
// TX    | returning ack / error / read bytes, low byte first
module riscv_soft_host_loader
  import riscv_soft_host_loader_pkg::*;
#(
  parameter int         XPR_LEN  = HOST_XPR_LEN,
  parameter logic [7:0] ACK_BYTE = 8'hA5,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [7:0]         rx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  input  logic               host_req_ready,
  output logic               host_req_valid,
  output logic [1:0]         host_req_op,
  output logic [2:0]         host_req_op_type,
  output logic [XPR_LEN-1:0] host_req_addr,
  output logic [XPR_LEN-1:0] host_req_data,
  input  logic               host_resp_valid,
  input  logic [XPR_LEN-1:0] host_resp_data,
  output logic               busy
);

  loader_state_e      state_q;
  logic               rx_ready_q;
  logic               is_write_q;
  logic [1:0]         byte_cnt_q;
  logic [1:0]         op_q;
  logic [XPR_LEN-1:0] addr_q;
  logic [XPR_LEN-1:0] data_q;
  logic               req_valid_q;
  logic [XPR_LEN-1:0] tx_sh_q;
  logic [2:0]         tx_cnt_q;

  // Command sequencer: frame assembly, request handshake, response serialization.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rx_ready_q  <= 1'b0;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= 2'd0;
      op_q        <= MEM_LOAD;
      addr_q      <= '0;
      data_q      <= '0;
      req_valid_q <= 1'b0;
      tx_sh_q     <= '0;
      tx_cnt_q    <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // rx_ready comes up one cycle after reset release and stays up here
          rx_ready_q <= 1'b1;
          if (rx_valid && rx_ready_q) begin
            byte_cnt_q <= 2'd0;
            if (rx_data == OPC_WRITE || rx_data == OPC_READ) begin
              is_write_q <= (rx_data == OPC_WRITE);
              op_q       <= (rx_data == OPC_WRITE) ? MEM_STORE : MEM_LOAD;
              state_q    <= S_ADDR;
            end else begin
              tx_sh_q    <= {{(XPR_LEN-8){1'b0}}, ERR_BYTE};
              tx_cnt_q   <= 3'd1;
              rx_ready_q <= 1'b0;
              state_q    <= S_TX;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (is_write_q) begin
                state_q <= S_DATA;
              end else begin
                state_q     <= S_REQ;
                req_valid_q <= 1'b1;
                rx_ready_q  <= 1'b0;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            data_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
              rx_ready_q  <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (host_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (host_resp_valid) begin
            if (is_write_q) begin
              tx_sh_q  <= {{(XPR_LEN-8){1'b0}}, ACK_BYTE};
              tx_cnt_q <= 3'd1;
            end else begin
              tx_sh_q  <= host_resp_data;
              tx_cnt_q <= 3'd4;
            end
            state_q <= S_TX;
          end
        end
        S_TX: begin
          if (tx_ready) begin
            tx_sh_q  <= {8'h00, tx_sh_q[XPR_LEN-1:8]};
            tx_cnt_q <= tx_cnt_q - 3'd1;
            if (tx_cnt_q == 3'd1) begin
              state_q    <= S_IDLE;
              rx_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready         = rx_ready_q;
  assign tx_valid         = (state_q == S_TX);
  assign tx_data          = tx_sh_q[7:0];
  assign host_req_valid   = req_valid_q;
  assign host_req_op      = op_q;
  assign host_req_op_type = MEM_TYPE_W;
  assign host_req_addr    = addr_q;
  assign host_req_data    = data_q;
  assign busy             = (state_q != S_IDLE);

endmodule
